sim_dtm_queue: RTL and testbench
================================

# sim_dtm_queue

Simulation-only debug transport module. A DPI-C tick produces debug requests, which are buffered in a parametrised FIFO and presented on a valid/ready request port toward the debug module. An optional response return path tracks outstanding requests and hands responses back to C. It sits at the testbench top in place of the single-register debug request driver, so host requests are no longer lost under backpressure.

## Interface
- ADDR_W, 32: request address width, 1..32; low bits of the DPI int are used.
- DATA_W, 32: request/response data width, 1..32.
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- MAX_OUT, 2: maximum outstanding requests, 1..255 (used only with the response path).

- clock  input  1  sampling clock; the DPI tick is called on the falling edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  output  1  FIFO head valid.
- req_bits_addr  output  ADDR_W  head address.
- req_bits_data  output  DATA_W  head data.
- req_bits_op  output  2  head opcode: 0 nop, 1 read, 2 write, 3 reserved and passed through.
- req_ready  input  1  consumer accepts the head.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a DPI request arrived while the FIFO was full.
- resp_valid  input  1  response present (response path only).
- resp_bits_data  input  DATA_W  response data (response path only).
- resp_bits_resp  input  2  response status (response path only).
- resp_ready  output  1  constant 1 after reset (response path only).
- outstanding  output  8  accepted-but-unanswered request count (response path only).
- resp_err  output  1  sticky: a response arrived with outstanding==0 (response path only).

## Operation
- DPI tick: int debug_tick(output bit valid, input bit ready, output int addr, output int data, output int op).
  - Called every falling edge while reset_n=1; never called while reset_n=0.
  - ready = !full, sampled at that falling edge.
- Capture: the tick outputs are registered into a staging set (valid, addr, data, op).
- Push: at the next rising edge, if staged valid=1 and the FIFO is not full, push {addr, data, op}.
  - If staged valid=1 and the FIFO is full, drop the entry and set overflow.
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty; pointers wrap modulo 2·DEPTH.
- req_valid = !empty, gated low when outstanding==MAX_OUT (response path only).
- Pop: on a rising edge with req_valid && req_ready.
  - Push and pop in the same edge keep fifo_count unchanged.
  - No bypass: an entry pushed into an empty FIFO is visible only after that edge.
- Response path:
  - outstanding increments on a pop with op 1 or 2.
  - outstanding decrements on resp_valid, which is accepted every edge.
  - Pop and response in the same edge leave outstanding unchanged.
  - A response with outstanding==0 sets resp_err; outstanding stays 0.
  - An accepted response is latched and delivered at the following falling edge via void debug_resp(int data, int resp), called once per response.
- Without the response path, outstanding is not tracked and req_valid gating is absent.

## Timing
- Reset values (asynchronous assert): req_valid 0, req_bits_* 0, fifo_count 0, overflow 0, staging valid 0, pointers 0, outstanding 0, resp_err 0, resp_ready 0.
- resp_ready rises at the first rising edge after deassertion.
- Latency: tick valid at falling edge N → push at rising edge N+1 → req_valid high after that edge. Minimum is half a cycle plus one edge, identical to the single-register driver.
- Throughput: one push and one pop per cycle.
- Reset mid-operation:
  - FIFO contents, the staged request and any pending response delivery are discarded.
  - The DPI is not informed.
  - Sticky flags clear.
- Output stability: req_bits_* change only on a pop or on a push into an empty FIFO; they hold while req_valid && !req_ready.

## Configuration
- SIM_DTM_RESP_EN defined: response ports, the outstanding counter, MAX_OUT gating, resp_err and the debug_resp import are compiled in.
- Not defined: none of these ports or the import exist; the block is a pure buffered request source.

## Test plan
- Tick emits 3 writes (addr 0x10/0x14/0x18, data 1/2/3), req_ready=1 → each appears one edge after its push; fifo_count peaks at 1; order preserved.
- req_ready=0 with DEPTH=4 and 6 tick requests → fifo_count reaches 4 and the tick sees ready=0; a force-valid-when-not-ready C stub sets overflow=1; raising req_ready drains entries 0..3 in order.
- Simultaneous push and pop at fifo_count=2 for 10 cycles → fifo_count stays 2; pointers wrap past 2·DEPTH correctly.
- RESP_EN with MAX_OUT=2 and 3 reads, no responses → req_valid drops after 2 pops and outstanding=2; one response (data 0xAB, resp 0) → debug_resp(0xAB,0) at the next falling edge and the third request issues.
- RESP_EN with a response while outstanding=0 → resp_err=1 and outstanding stays 0.
- reset_n pulsed low with fifo_count=3 and a response pending → all outputs return to reset values immediately; no debug_resp call; the tick resumes at the first falling edge after release.

Source files
------------

// File: rtl/sim_dtm_queue.sv
// Buffered debug-request source: falling-edge tick -> staging -> FIFO -> valid/ready port.
// SIM_DTM_RESP_EN adds the response path; ticks are sourced from the tick_* ports.
module sim_dtm_queue #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     req_valid,
  output logic [ADDR_W-1:0]        req_bits_addr,
  output logic [DATA_W-1:0]        req_bits_data,
  output logic [1:0]               req_bits_op,
  input  logic                     req_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef SIM_DTM_RESP_EN
  ,
  input  logic                     resp_valid,
  input  logic [DATA_W-1:0]        resp_bits_data,
  input  logic [1:0]               resp_bits_resp,
  output logic                     resp_ready,
  output logic [7:0]               outstanding,
  output logic                     resp_err
`endif
  ,
  input  logic                     tick_valid,
  input  logic [ADDR_W-1:0]        tick_addr,
  input  logic [DATA_W-1:0]        tick_data,
  input  logic [1:0]               tick_op,
  output logic                     tick_ready
`ifdef SIM_DTM_RESP_EN
  ,
  output logic                     dresp_valid,
  output logic [DATA_W-1:0]        dresp_data,
  output logic [1:0]               dresp_resp
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic              r_stg_valid;
  logic [ADDR_W-1:0] r_stg_addr;
  logic [DATA_W-1:0] r_stg_data;
  logic [1:0]        r_stg_op;

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [1:0]        r_mem_op   [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_gate;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [1:0]        w_head_op;

  // Equal low bits with differing MSB means the writer is a full lap ahead.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = r_stg_valid && !w_full;
  assign w_pop   = req_valid && req_ready;

  assign w_head_addr = r_mem_addr[r_rd_ptr[AW-1:0]];
  assign w_head_data = r_mem_data[r_rd_ptr[AW-1:0]];
  assign w_head_op   = r_mem_op[r_rd_ptr[AW-1:0]];

  assign req_valid     = !w_empty && !w_gate;
  assign req_bits_addr = w_empty ? '0 : w_head_addr;
  assign req_bits_data = w_empty ? '0 : w_head_data;
  assign req_bits_op   = w_empty ? '0 : w_head_op;
  assign fifo_count    = r_wr_ptr - r_rd_ptr;
  assign overflow      = r_overflow;

  assign tick_ready = !w_full;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
      r_stg_op    <= '0;
    end else begin
      r_stg_valid <= tick_valid;
      r_stg_addr  <= tick_addr;
      r_stg_data  <= tick_data;
      r_stg_op    <= tick_op;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[AW-1:0]] <= r_stg_addr;
      r_mem_data[r_wr_ptr[AW-1:0]] <= r_stg_data;
      r_mem_op[r_wr_ptr[AW-1:0]]   <= r_stg_op;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (r_stg_valid && w_full) r_overflow <= 1'b1;
    end
  end

`ifdef SIM_DTM_RESP_EN
  logic [7:0]        r_outstanding;
  logic              r_resp_err;
  logic              r_resp_ready;
  logic              r_resp_pend;
  logic [DATA_W-1:0] r_resp_data;
  logic [1:0]        r_resp_code;
  logic              w_issue;
  logic              w_retire;

  assign w_gate   = (r_outstanding == 8'(MAX_OUT));
  assign w_issue  = w_pop && ((w_head_op == 2'd1) || (w_head_op == 2'd2));
  assign w_retire = resp_valid && (r_outstanding != 8'd0);

  assign resp_ready  = r_resp_ready;
  assign outstanding = r_outstanding;
  assign resp_err    = r_resp_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= 8'd0;
      r_resp_err    <= 1'b0;
      r_resp_ready  <= 1'b0;
      r_resp_pend   <= 1'b0;
      r_resp_data   <= '0;
      r_resp_code   <= '0;
    end else begin
      r_resp_ready <= 1'b1;
      if (w_issue && !w_retire)      r_outstanding <= r_outstanding + 8'd1;
      else if (!w_issue && w_retire) r_outstanding <= r_outstanding - 8'd1;
      if (resp_valid && (r_outstanding == 8'd0)) r_resp_err <= 1'b1;
      // Latched here, handed back to the host on the following falling edge.
      r_resp_pend <= resp_valid;
      if (resp_valid) begin
        r_resp_data <= resp_bits_data;
        r_resp_code <= resp_bits_resp;
      end
    end
  end

  logic              r_dlv_valid;
  logic [DATA_W-1:0] r_dlv_data;
  logic [1:0]        r_dlv_resp;

  assign dresp_valid = r_dlv_valid;
  assign dresp_data  = r_dlv_data;
  assign dresp_resp  = r_dlv_resp;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dlv_valid <= 1'b0;
      r_dlv_data  <= '0;
      r_dlv_resp  <= '0;
    end else begin
      r_dlv_valid <= r_resp_pend;
      r_dlv_data  <= r_resp_data;
      r_dlv_resp  <= r_resp_code;
    end
  end
`else
  assign w_gate = 1'b0;
`endif

endmodule

// File: tb/tb_sim_dtm_queue.sv
// Directed bench for sim_dtm_queue with tick ports; response tests compile in with SIM_DTM_RESP_EN.
module tb_sim_dtm_queue;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_bits_addr;
  logic [31:0] req_bits_data;
  logic [1:0]  req_bits_op;
  logic        req_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        tick_valid;
  logic [31:0] tick_addr;
  logic [31:0] tick_data;
  logic [1:0]  tick_op;
  logic        tick_ready;
`ifdef SIM_DTM_RESP_EN
  logic        resp_valid;
  logic [31:0] resp_bits_data;
  logic [1:0]  resp_bits_resp;
  logic        resp_ready;
  logic [7:0]  outstanding;
  logic        resp_err;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic [1:0]  dresp_resp;
  localparam logic [1:0] T1_OP = 2'd0;
`else
  localparam logic [1:0] T1_OP = 2'd2;
`endif

  int n_vec;
  int n_bad;

  sim_dtm_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_bits_addr(req_bits_addr), .req_bits_data(req_bits_data),
    .req_bits_op(req_bits_op), .req_ready(req_ready),
    .fifo_count(fifo_count), .overflow(overflow),
`ifdef SIM_DTM_RESP_EN
    .resp_valid(resp_valid), .resp_bits_data(resp_bits_data), .resp_bits_resp(resp_bits_resp),
    .resp_ready(resp_ready), .outstanding(outstanding), .resp_err(resp_err),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data), .dresp_resp(dresp_resp),
`endif
    .tick_valid(tick_valid), .tick_addr(tick_addr), .tick_data(tick_data),
    .tick_op(tick_op), .tick_ready(tick_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "bench timeout");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_tick(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] o);
    tick_valid = v;
    tick_addr  = a;
    tick_data  = d;
    tick_op    = o;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_ready = 1'b0;
    set_tick(1'b0, 32'd0, 32'd0, 2'd0);
`ifdef SIM_DTM_RESP_EN
    resp_valid = 1'b0; resp_bits_data = '0; resp_bits_resp = '0;
`endif
    cyc(); cyc();
    n_vec++;
    if ({req_valid, req_bits_addr, req_bits_data, req_bits_op, fifo_count, overflow, tick_ready} !==
        {1'b0, 32'd0, 32'd0, 2'd0, 3'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%0b a=%h d=%h op=%0d cnt=%0d ovf=%0b rdy=%0b want all zero, rdy=1",
               req_valid, req_bits_addr, req_bits_data, req_bits_op, fifo_count, overflow, tick_ready);
    end
`ifdef SIM_DTM_RESP_EN
    n_vec++;
    if ({resp_ready, outstanding, resp_err, dresp_valid} !== {1'b0, 8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_resp: got rr=%0b out=%0d err=%0b dv=%0b want 0 0 0 0",
               resp_ready, outstanding, resp_err, dresp_valid);
    end
`endif
    reset_n = 1'b1;
    cyc();
`ifdef SIM_DTM_RESP_EN
    n_vec++;
    if (resp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL resp_ready_rise: got %0b want 1", resp_ready);
    end
`endif
    n_vec++;
    if ({req_valid, fifo_count} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL idle_after_reset: got v=%0b cnt=%0d want 0 0", req_valid, fifo_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_order();
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_tick(1'b1, 32'h10 + 32'(4 * i), 32'(i + 1), T1_OP);
      cyc();
      n_vec++;
      if ({req_valid, fifo_count, req_bits_addr, req_bits_data, req_bits_op} !==
          {1'b1, 3'd1, 32'h10 + 32'(4 * i), 32'(i + 1), T1_OP}) begin
        n_bad++;
        $display("FAIL order_head%0d: got v=%0b cnt=%0d a=%h d=%h op=%0d want 1 1 %h %h %0d", i,
                 req_valid, fifo_count, req_bits_addr, req_bits_data, req_bits_op,
                 32'h10 + 32'(4 * i), 32'(i + 1), T1_OP);
      end
      $display("order: entry %0d addr %h data %h cnt %0d", i, req_bits_addr, req_bits_data, fifo_count);
    end
    set_tick(1'b0, 32'd0, 32'd0, 2'd0);
    cyc();
    n_vec++;
    if ({req_valid, fifo_count, req_bits_addr} !== {1'b0, 3'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL order_empty: got v=%0b cnt=%0d a=%h want 0 0 0", req_valid, fifo_count, req_bits_addr);
    end
  endtask

  task automatic test_backpressure();
    int exp_cnt;
    req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_tick(1'b1, 32'h100 + 32'(i), 32'hA0 + 32'(i), 2'd3);
      cyc();
      exp_cnt = (i + 1 < 4) ? i + 1 : 4;
      n_vec++;
      if ({req_valid, fifo_count, overflow, tick_ready, req_bits_addr} !==
          {1'b1, 3'(exp_cnt), (i >= 4), (exp_cnt < 4), 32'h100}) begin
        n_bad++;
        $display("FAIL fill%0d: got v=%0b cnt=%0d ovf=%0b rdy=%0b a=%h want 1 %0d %0b %0b 100", i,
                 req_valid, fifo_count, overflow, tick_ready, req_bits_addr, exp_cnt, (i >= 4), (exp_cnt < 4));
      end
      $display("fill: tick %0d cnt %0d ovf %0b rdy %0b", i, fifo_count, overflow, tick_ready);
    end
    set_tick(1'b0, 32'd0, 32'd0, 2'd0);
    req_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if ({req_valid, fifo_count, req_bits_addr, req_bits_data, req_bits_op} !==
          {1'b1, 3'(4 - j), 32'h100 + 32'(j), 32'hA0 + 32'(j), 2'd3}) begin
        n_bad++;
        $display("FAIL drain%0d: got v=%0b cnt=%0d a=%h d=%h op=%0d want 1 %0d %h %h 3", j,
                 req_valid, fifo_count, req_bits_addr, req_bits_data, req_bits_op,
                 4 - j, 32'h100 + 32'(j), 32'hA0 + 32'(j));
      end
      $display("drain: entry %0d addr %h", j, req_bits_addr);
      cyc();
    end
    n_vec++;
    if ({req_valid, fifo_count, overflow} !== {1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL drain_end: got v=%0b cnt=%0d ovf=%0b want 0 0 1", req_valid, fifo_count, overflow);
    end
  endtask

  task automatic test_back_to_back();
    req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_tick(1'b1, 32'h200 + 32'(i), 32'(i), 2'd3);
      cyc();
    end
    req_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      set_tick(1'b1, 32'h200 + 32'(i), 32'(i), 2'd3);
      cyc();
      n_vec++;
      if ({req_valid, fifo_count, req_bits_addr, req_bits_data} !==
          {1'b1, 3'd2, 32'h200 + 32'(i - 1), 32'(i - 1)}) begin
        n_bad++;
        $display("FAIL b2b%0d: got v=%0b cnt=%0d a=%h d=%h want 1 2 %h %h", i,
                 req_valid, fifo_count, req_bits_addr, req_bits_data, 32'h200 + 32'(i - 1), 32'(i - 1));
      end
      $display("b2b: step %0d head %h cnt %0d", i, req_bits_addr, fifo_count);
    end
    set_tick(1'b0, 32'd0, 32'd0, 2'd0);
    cyc();
    n_vec++;
    if ({fifo_count, req_bits_addr} !== {3'd1, 32'h20B}) begin
      n_bad++;
      $display("FAIL b2b_tail: got cnt=%0d a=%h want 1 20b", fifo_count, req_bits_addr);
    end
    cyc();
    n_vec++;
    if ({req_valid, fifo_count} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL b2b_empty: got v=%0b cnt=%0d want 0 0", req_valid, fifo_count);
    end
  endtask

`ifdef SIM_DTM_RESP_EN
  task automatic test_resp_gate();
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_tick(1'b1, 32'h300 + 32'(i), 32'(i), 2'd1);
      cyc();
    end
    set_tick(1'b0, 32'd0, 32'd0, 2'd0);
    n_vec++;
    if ({req_valid, fifo_count, outstanding} !== {1'b0, 3'd1, 8'd2}) begin
      n_bad++;
      $display("FAIL gate_hit: got v=%0b cnt=%0d out=%0d want 0 1 2", req_valid, fifo_count, outstanding);
    end
    cyc();
    n_vec++;
    if ({req_valid, fifo_count, outstanding} !== {1'b0, 3'd1, 8'd2}) begin
      n_bad++;
      $display("FAIL gate_hold: got v=%0b cnt=%0d out=%0d want 0 1 2", req_valid, fifo_count, outstanding);
    end
    resp_valid = 1'b1; resp_bits_data = 32'hAB; resp_bits_resp = 2'd0;
    cyc();
    resp_valid = 1'b0;
    n_vec++;
    if ({req_valid, outstanding, req_bits_addr, dresp_valid} !== {1'b1, 8'd1, 32'h302, 1'b0}) begin
      n_bad++;
      $display("FAIL gate_release: got v=%0b out=%0d a=%h dv=%0b want 1 1 302 0",
               req_valid, outstanding, req_bits_addr, dresp_valid);
    end
    @(negedge clock);
    #1;
    n_vec++;
    if ({dresp_valid, dresp_data, dresp_resp} !== {1'b1, 32'hAB, 2'd0}) begin
      n_bad++;
      $display("FAIL resp_deliver: got dv=%0b d=%h r=%0d want 1 ab 0", dresp_valid, dresp_data, dresp_resp);
    end
    $display("resp: delivered data %h resp %0d", dresp_data, dresp_resp);
    cyc();
    n_vec++;
    if ({outstanding, fifo_count} !== {8'd2, 3'd0}) begin
      n_bad++;
      $display("FAIL third_issue: got out=%0d cnt=%0d want 2 0", outstanding, fifo_count);
    end
    resp_valid = 1'b1; resp_bits_data = 32'd0;
    cyc(); cyc();
    resp_valid = 1'b0;
    n_vec++;
    if ({outstanding, resp_err} !== {8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL retire_all: got out=%0d err=%0b want 0 0", outstanding, resp_err);
    end
  endtask

  task automatic test_resp_err();
    resp_valid = 1'b1;
    cyc();
    resp_valid = 1'b0;
    n_vec++;
    if ({resp_err, outstanding} !== {1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL resp_err: got err=%0b out=%0d want 1 0", resp_err, outstanding);
    end
  endtask
`endif

  task automatic test_reset_midop();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_tick(1'b1, 32'h380 + 32'(i), 32'(i), 2'd0);
      cyc();
    end
`ifdef SIM_DTM_RESP_EN
    resp_valid = 1'b1;
`endif
    set_tick(1'b1, 32'h3FF, 32'd9, 2'd0);
    cyc();
`ifdef SIM_DTM_RESP_EN
    resp_valid = 1'b0;
`endif
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({req_valid, req_bits_addr, req_bits_data, fifo_count, overflow} !==
        {1'b0, 32'd0, 32'd0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL midop_reset: got v=%0b a=%h d=%h cnt=%0d ovf=%0b want 0 0 0 0 0",
               req_valid, req_bits_addr, req_bits_data, fifo_count, overflow);
    end
    set_tick(1'b1, 32'h3EE, 32'd7, 2'd0);
    @(negedge clock);
    #1;
`ifdef SIM_DTM_RESP_EN
    n_vec++;
    if ({dresp_valid, resp_ready, resp_err, outstanding} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL midop_resp: got dv=%0b rr=%0b err=%0b out=%0d want 0 0 0 0",
               dresp_valid, resp_ready, resp_err, outstanding);
    end
`endif
    cyc();
    n_vec++;
    if ({req_valid, fifo_count} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL midop_hold: got v=%0b cnt=%0d want 0 0", req_valid, fifo_count);
    end
    reset_n = 1'b1;
    set_tick(1'b1, 32'h400, 32'h44, 2'd0);
    cyc();
    set_tick(1'b0, 32'd0, 32'd0, 2'd0);
    n_vec++;
    if ({req_valid, fifo_count, req_bits_addr, req_bits_data} !== {1'b1, 3'd1, 32'h400, 32'h44}) begin
      n_bad++;
      $display("FAIL midop_resume: got v=%0b cnt=%0d a=%h d=%h want 1 1 400 44",
               req_valid, fifo_count, req_bits_addr, req_bits_data);
    end
    $display("midop: resumed head %h", req_bits_addr);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_order();
    test_backpressure();
    test_back_to_back();
`ifdef SIM_DTM_RESP_EN
    test_resp_gate();
    test_resp_err();
`endif
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
